// File: rtl/patt_stream_gen.sv
// Serial pattern transmitter: streams PATTERN MSB-first over a valid/ready
// handshake, repeat_cnt copies separated by gap_len FILL_BIT bits.
module patt_stream_gen #(
  parameter int unsigned            NUM_BITS = 5,
  parameter logic [NUM_BITS-1:0]    PATTERN  = 5'b10110,
  parameter int unsigned            GAP_W    = 4,
  parameter int unsigned            CNT_W    = 8,
  parameter logic                   FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             ready,
  output logic             valid,
  output logic             data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int unsigned      IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PATT,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   sent_inc;
  logic               valid_q, valid_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gcnt_d   = gcnt_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    sent_d   = sent_q;
    sent_inc = sent_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rep_d  = repeat_cnt;
          gap_d  = gap_len;
          sent_d = '0;
          if (repeat_cnt != '0) begin
            state_d = ST_PATT;
            idx_d   = IDX_TOP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PATT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            sent_d = sent_inc;
            if (sent_inc == rep_q) begin
              state_d = ST_DONE;
            end else if (gap_q == '0) begin
              idx_d = IDX_TOP;
            end else begin
              state_d = ST_GAP;
              gcnt_d  = gap_q;
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready) begin
          gcnt_d = gcnt_q - 1'b1;
          if (gcnt_q == GAP_W'(1)) begin
            state_d = ST_PATT;
            idx_d   = IDX_TOP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    valid_d = (state_d == ST_PATT) || (state_d == ST_GAP);
    busy_d  = valid_d;
    done_d  = (state_d == ST_DONE);
    if (state_d == ST_PATT) begin
      data_d = PATTERN[idx_d];
    end else if (state_d == ST_GAP) begin
      data_d = FILL_BIT;
    end else begin
      data_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gcnt_q  <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      sent_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      sent_q  <= sent_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_patt_stream_gen.sv
// Scoreboard bench for patt_stream_gen: a sequence model fills the expected
// bit queue per burst, a negedge monitor pops and compares on each transfer.
module tb_patt_stream_gen;

  localparam int          NB    = 5;
  localparam logic [4:0]  PAT   = 5'b10110;
  localparam logic        FILL  = 1'b0;
  localparam int          LIMIT = 4000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       valid, data, busy, done;
  logic [7:0] sent_cnt;

  patt_stream_gen #(
    .NUM_BITS(NB),
    .PATTERN (PAT),
    .GAP_W   (4),
    .CNT_W   (8),
    .FILL_BIT(FILL)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .repeat_cnt(repeat_cnt),
    .gap_len   (gap_len),
    .ready     (ready),
    .valid     (valid),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         exp_q[$];
  int         n_xfer   = 0;
  int         done_cnt = 0;
  int         exp_sent = 0;
  bit         prev_stall = 1'b0;
  logic       prev_data = 1'b0;
  bit         mon_bit;
  int         rpat_i = 0;
  logic [4:0] pat_v = PAT;
  bit         rpat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when valid&&ready and no abort.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", valid, 1);
        check("stall_data", data, prev_data);
      end
      if (valid && ready && !abort) begin
        check("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_bit = exp_q.pop_front();
          check("data", data, mon_bit);
        end
        n_xfer++;
      end
      if (done) begin
        done_cnt++;
        check("done_sent_cnt", sent_cnt, exp_sent);
        check("done_valid", valid, 0);
        check("done_queue_empty", exp_q.size(), 0);
      end
      prev_stall = valid && !ready && !abort;
      prev_data  = data;
    end
  end

  // Reference: the burst is rep copies of PAT with gap FILL bits between them;
  // only the first 'limit' bits are expected, and sent counts whole copies within them.
  task automatic model_push(input int rep, input int gap, input int limit, output int sent);
    int pos;
    pos  = 0;
    sent = 0;
    for (int r = 0; r < rep; r++) begin
      for (int b = NB - 1; b >= 0; b--) begin
        if (pos < limit) exp_q.push_back(pat_v[b]);
        pos++;
      end
      if (pos <= limit) sent = r + 1;
      if (r < rep - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (pos < limit) exp_q.push_back(FILL);
          pos++;
        end
      end
    end
  endtask

  task automatic next_ready(input int mode, output logic r);
    case (mode)
      0: r = 1'b1;
      1: begin
        r = rpat[rpat_i];
        rpat_i = (rpat_i + 1) % 7;
      end
      default: r = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_burst(input int rep, input int gap, input int rmode,
                           input int abort_k, input bit spur);
    int   base, sent_e, cyc, d0, total;
    bit   aborted;
    logic r;
    total = (rep == 0) ? 0 : rep * NB + (rep - 1) * gap;
    model_push(rep, gap, (abort_k < 0) ? 32'h3fff_ffff : abort_k, sent_e);
    exp_sent = sent_e;
    d0       = done_cnt;
    rpat_i   = 0;
    @(posedge clk); #1;
    base       = n_xfer;
    start      = 1'b1;
    repeat_cnt = 8'(rep);
    gap_len    = 4'(gap);
    next_ready(rmode, r);
    ready      = r;
    @(posedge clk); #1;
    start      = 1'b0;
    repeat_cnt = 8'($urandom);
    gap_len    = 4'($urandom);
    if (rep != 0) begin
      check("start_valid", valid, 1);
      check("start_msb", data, pat_v[NB-1]);
    end else begin
      check("zero_rep_done", done, 1);
      check("zero_rep_valid", valid, 0);
    end
    cyc     = 0;
    aborted = 1'b0;
    while (busy && cyc < LIMIT) begin
      next_ready(rmode, r);
      ready = r;
      start = 1'b0;
      abort = 1'b0;
      if (abort_k >= 0 && !aborted && (n_xfer - base) == abort_k) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end else if (spur && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sent_cnt", sent_cnt, exp_sent);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check("burst_in_budget", cyc < LIMIT, 1);
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt - d0, (abort_k < 0) ? 1 : 0);
    check("idle_valid", valid, 0);
    check("final_sent_cnt", sent_cnt, exp_sent);
    check("queue_drained", exp_q.size(), 0);
    if (abort_k < 0) check("xfer_count", n_xfer - base, total);
  endtask

  task automatic reset_mid_gap();
    int base, s, cyc;
    model_push(3, 4, 32'h3fff_ffff, s);
    exp_sent = s;
    @(posedge clk); #1;
    base       = n_xfer;
    start      = 1'b1;
    repeat_cnt = 8'd3;
    gap_len    = 4'd4;
    ready      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while ((n_xfer - base) < 7 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_reset_in_budget", cyc < 100, 1);
    check("pre_reset_sent_cnt", sent_cnt, 1);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_fill", data, FILL);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_data", data, 0);
    check("async_rst_sent_cnt", sent_cnt, 0);
    check("async_rst_done", done, 0);
    exp_q.delete();
    ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_valid", valid, 0);
  endtask

  initial begin
    int rep, gap, mode, k, total;
    #12;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    run_burst(1, 0, 0, -1, 1'b0);
    run_burst(3, 2, 0, -1, 1'b1);
    run_burst(2, 0, 1, -1, 1'b0);
    run_burst(0, 3, 0, -1, 1'b0);
    run_burst(4, 1, 0, 7, 1'b0);
    run_burst(1, 0, 0, -1, 1'b0);
    reset_mid_gap();
    run_burst(2, 1, 2, -1, 1'b1);
    run_burst(255, 0, 0, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rep   = $urandom_range(0, 6);
      gap   = $urandom_range(0, 3);
      mode  = $urandom_range(0, 2);
      total = (rep == 0) ? 0 : rep * NB + (rep - 1) * gap;
      k     = -1;
      if (rep != 0 && $urandom_range(0, 3) == 0) k = $urandom_range(0, total - 1);
      run_burst(rep, gap, mode, k, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
